// File: rtl/sram_host_ctrl.sv
// Host-side controller for the single-port RW port of the sram macro: drives csb/web/wmask
// combinationally on accept, captures dout one cycle later and queues in-order responses.
module sram_host_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [31:0]           req_addr_i,
  input  logic [NUM_WMASKS-1:0] req_be_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_we_o,
  output logic                  rsp_err_o,
  output logic                  sram_csb_o,
  output logic                  sram_web_o,
  output logic [NUM_WMASKS-1:0] sram_wmask_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_din_o,
  input  logic [DATA_WIDTH-1:0] sram_dout_i
);

  localparam int DEPTH = 3;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  we;
    logic                  err;
  } rsp_t;

  // Handshake: a transfer happens on a rising edge where valid && ready; valid must
  // not depend on ready, and the payload is held stable while valid is high.
  logic       req_err;
  logic       accept;
  logic       push;
  logic       pop;
  logic       pend_q, pend_we_q, pend_err_q;
  logic [1:0] count_q, wr_ptr_q, rd_ptr_q;
  rsp_t       fifo_q [DEPTH];
  rsp_t       push_entry;
  rsp_t       head;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    req_err = (req_addr_i[1:0] != 2'b00) || (req_addr_i[31:ADDR_WIDTH+2] != '0);
  end

  // The slot for a request is reserved at accept (pend), so pushes never overflow and
  // ready depends only on registered state, never on rsp_ready_i.
  assign req_ready_o = rst_ni && (({1'b0, count_q} + {2'b00, pend_q}) < 3'd3);
  assign accept      = req_valid_i && req_ready_o;

  assign sram_csb_o   = !(accept && !req_err);
  assign sram_web_o   = !req_we_i;
  assign sram_wmask_o = req_we_i ? req_be_i : '0;
  assign sram_addr_o  = req_addr_i[ADDR_WIDTH+1:2];
  assign sram_din_o   = req_wdata_i;

  assign push = pend_q;
  assign pop  = rsp_valid_o && rsp_ready_i;

  always_comb begin
    push_entry.rdata = (pend_we_q || pend_err_q) ? '0 : sram_dout_i;
    push_entry.we    = pend_we_q;
    push_entry.err   = pend_err_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q     <= 1'b0;
      pend_we_q  <= 1'b0;
      pend_err_q <= 1'b0;
    end else begin
      pend_q <= accept;
      if (accept) begin
        pend_we_q  <= req_we_i;
        pend_err_q <= req_err;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 2'd0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= push_entry;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head fields are masked while empty so idle outputs read as zero.
  assign head        = fifo_q[rd_ptr_q];
  assign rsp_valid_o = (count_q != 2'd0);
  assign rsp_rdata_o = rsp_valid_o ? head.rdata : '0;
  assign rsp_we_o    = rsp_valid_o && head.we;
  assign rsp_err_o   = rsp_valid_o && head.err;

endmodule

// File: tb/tb_sram_host_ctrl.sv
// Bench for sram_host_ctrl: behavioural sram macro model, request driver, and a
// scoreboard monitor that pops expected {rdata, we, err} whenever a response is taken.
module tb_sram_host_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [3:0]  req_be_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_we_o;
  logic        rsp_err_o;
  logic        sram_csb_o;
  logic        sram_web_o;
  logic [3:0]  sram_wmask_o;
  logic [9:0]  sram_addr_o;
  logic [31:0] sram_din_o;
  logic [31:0] sram_dout_i;

  sram_host_ctrl #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .NUM_WMASKS(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_be_i(req_be_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_we_o(rsp_we_o), .rsp_err_o(rsp_err_o),
    .sram_csb_o(sram_csb_o), .sram_web_o(sram_web_o), .sram_wmask_o(sram_wmask_o),
    .sram_addr_o(sram_addr_o), .sram_din_o(sram_din_o), .sram_dout_i(sram_dout_i)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- sram macro model ----------------
  logic        m_csb = 1'b1, m_web = 1'b1;
  logic [3:0]  m_wmask = '0;
  logic [9:0]  m_addr = '0;
  logic [31:0] m_din = '0;
  logic [31:0] mem [1024];
  logic [31:0] dout = '0;
  assign sram_dout_i = dout;

  always @(posedge clk_i) begin
    m_csb   <= sram_csb_o;
    m_web   <= sram_web_o;
    m_wmask <= sram_wmask_o;
    m_addr  <= sram_addr_o;
    m_din   <= sram_din_o;
  end

  always @(negedge clk_i) begin
    if (!m_csb) begin
      if (!m_web) begin
        for (int b = 0; b < 4; b++)
          if (m_wmask[b]) mem[m_addr][b*8 +: 8] <= m_din[b*8 +: 8];
      end else begin
        dout <= mem[m_addr];
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];
  int          acc_q[$];
  bit          lat_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          chk_lat = 1'b0;
  int          acc_dummy;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [33:0] rsp(input logic [31:0] rdata, input logic we, input logic err);
    return {rdata, we, err};
  endfunction

  // Monitor: a response is consumed on the edge following this negedge.
  always @(negedge clk_i) begin
    if (rst_ni && rsp_valid_o && rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_rsp: got 0x%0h with empty queue (t=%0t)",
                 {rsp_rdata_o, rsp_we_o, rsp_err_o}, $time);
      end else begin
        logic [33:0] e;
        int          a;
        bit          l;
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        l = lat_q.pop_front();
        check("rsp_data", {rsp_rdata_o, rsp_we_o, rsp_err_o}, e);
        if (l) check("rsp_latency", 34'(cyc - a), 34'd2);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, input logic [33:0] exp, output int acc);
    int waited;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_be_i    = be;
    req_wdata_i = wdata;
    waited      = 0;
    acc         = -1;
    while (acc < 0 && waited < 200) begin
      @(negedge clk_i);
      if (req_ready_o) begin
        acc = cyc;
        check("csb_on_accept", {33'd0, sram_csb_o}, {33'd0, exp[0]});
        if (!exp[0]) check("web_on_accept", {33'd0, sram_web_o}, {33'd0, !we});
        exp_q.push_back(exp);
        acc_q.push_back(cyc);
        lat_q.push_back(chk_lat);
      end
      @(posedge clk_i);
      #1;
      waited++;
    end
    if (acc < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: addr 0x%0h never accepted (t=%0t)", addr, $time);
    end
    req_valid_i = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [33:0] exp);
    issue(1'b0, addr, 4'h0, 32'h0, exp, acc_dummy);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
    issue(1'b1, addr, be, data, rsp(32'h0, 1'b1, 1'b0), acc_dummy);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int prev, a;
    // reset values
    #3;
    check("rst_ready", {33'd0, req_ready_o}, 34'd0);
    check("rst_rsp", {rsp_rdata_o, rsp_we_o, rsp_err_o}, 34'd0);
    check("rst_valid", {33'd0, rsp_valid_o}, 34'd0);
    check("rst_csb", {33'd0, sram_csb_o}, 34'd1);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    #1 check("rel_ready", {33'd0, req_ready_o}, 34'd1);

    // preload words 0..63 with 0xA500_00ii
    rsp_ready_i = 1'b1;
    chk_lat = 1'b1;
    for (int i = 0; i < 64; i++) wr(32'(i * 4), 4'hF, 32'hA500_0000 | 32'(i));

    // streaming: 64 back-to-back reads, each accepted the cycle after the previous
    prev = -1;
    for (int i = 0; i < 64; i++) begin
      issue(1'b0, 32'(i * 4), 4'h0, 32'h0, rsp(32'hA500_0000 | 32'(i), 1'b0, 1'b0), a);
      if (prev >= 0) check("stream_gap", 34'(a - prev), 34'd1);
      prev = a;
    end

    // backpressure: only 3 of 5 accepted while rsp_ready_i=0
    repeat (4) @(posedge clk_i);
    #1;
    chk_lat = 1'b0;
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) rd(32'(i * 4), rsp(32'hA500_0000 | 32'(i), 1'b0, 1'b0));
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_addr_i  = 32'hC;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("bp_ready_low", {33'd0, req_ready_o}, 34'd0);
      check("bp_csb_high", {33'd0, sram_csb_o}, 34'd1);
    end
    @(posedge clk_i);
    #1 rsp_ready_i = 1'b1;
    rd(32'hC, rsp(32'hA500_0003, 1'b0, 1'b0));
    rd(32'h10, rsp(32'hA500_0004, 1'b0, 1'b0));
    repeat (6) @(posedge clk_i);
    #1;

    // errors interleaved with valid reads
    chk_lat = 1'b1;
    rd(32'h0, rsp(32'hA500_0000, 1'b0, 1'b0));
    rd(32'h13, rsp(32'h0, 1'b0, 1'b1));
    rd(32'h4, rsp(32'hA500_0001, 1'b0, 1'b0));
    rd(32'h1000, rsp(32'h0, 1'b0, 1'b1));
    issue(1'b1, 32'h1000, 4'hF, 32'h1234_5678, rsp(32'h0, 1'b1, 1'b1), acc_dummy);
    rd(32'h8, rsp(32'hA500_0002, 1'b0, 1'b0));

    // basic write then back-to-back read of the same word
    wr(32'h10, 4'hF, 32'hDEAD_BEEF);
    rd(32'h10, rsp(32'hDEAD_BEEF, 1'b0, 1'b0));

    // byte mask and empty-mask write
    wr(32'h20, 4'hF, 32'h1122_3344);
    wr(32'h20, 4'b0101, 32'hAABB_CCDD);
    rd(32'h20, rsp(32'h11BB_33DD, 1'b0, 1'b0));
    wr(32'h20, 4'h0, 32'hFFFF_FFFF);
    rd(32'h20, rsp(32'h11BB_33DD, 1'b0, 1'b0));
    repeat (6) @(posedge clk_i);
    #1;

    // reset mid-stream with 2 responses queued
    chk_lat = 1'b0;
    rsp_ready_i = 1'b0;
    rd(32'h0, rsp(32'hA500_0000, 1'b0, 1'b0));
    rd(32'h4, rsp(32'hA500_0001, 1'b0, 1'b0));
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("pre_rst_valid", {33'd0, rsp_valid_o}, 34'd1);
    #1;
    req_valid_i = 1'b1;
    req_addr_i  = 32'h8;
    rst_ni      = 1'b0;
    exp_q.delete();
    acc_q.delete();
    lat_q.delete();
    #1;
    check("mid_rst_valid", {33'd0, rsp_valid_o}, 34'd0);
    check("mid_rst_csb", {33'd0, sram_csb_o}, 34'd1);
    check("mid_rst_ready", {33'd0, req_ready_o}, 34'd0);
    @(negedge clk_i);
    rst_ni      = 1'b1;
    req_valid_i = 1'b0;
    #1 check("post_rst_ready", {33'd0, req_ready_o}, 34'd1);
    rsp_ready_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;
    check("no_stale_valid", {33'd0, rsp_valid_o}, 34'd0);
    chk_lat = 1'b1;
    rd(32'h8, rsp(32'hA500_0002, 1'b0, 1'b0));

    // drain
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk_i);
    repeat (2) @(posedge clk_i);
    check("queue_drained", 34'(exp_q.size()), 34'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
